fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 1024, sets the number of samples per FFT frame; legal values are powers of two from 64 to 4096.
REQ-002 Parameter DATA_W, default 24, sets the sample and FFT input width.
REQ-003 Parameter FIFO_DEPTH, default 4, sets the skid FIFO depth in entries; the depth is a power of two.
REQ-004 MCLK  in  1  50 MHz board clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level signal; high permits new frames to start.
REQ-007 sample_valid  in  1  one-cycle strobe per audio sample (once per LRCLK).
REQ-008 sample_data  in  DATA_W  signed audio sample, qualified by sample_valid.
REQ-009 sink_ready  in  1  FFT core is ready to accept input.
REQ-010 source_eop  in  1  FFT core end of output frame.
REQ-011 clear_ovf  in  1  one-cycle pulse that clears overflow.
REQ-012 sink_valid  out  1  sample presented to the FFT core.
REQ-013 sink_sop  out  1  first sample of a frame.
REQ-014 sink_eop  out  1  last sample of a frame.
REQ-015 sink_real  out  DATA_W  sample data.
REQ-016 sink_imag  out  DATA_W  constant zero.
REQ-017 busy  out  1  high while a frame is in progress (state STREAM).
REQ-018 overflow  out  1  sticky flag: a sample was dropped.
REQ-019 frames_in  out  16  count of frames fully sent to the FFT core.
REQ-020 frames_out  out  16  count of source_eop pulses received.

Function
REQ-021 Incoming samples SHALL be written to a FIFO_DEPTH-entry FIFO on every sample_valid cycle unless the FIFO is full and no pop occurs in the same cycle.
REQ-022 A push to a full FIFO with a simultaneous pop SHALL be accepted; a push to a full FIFO without a pop SHALL be dropped and SHALL set overflow.
REQ-023 overflow SHALL stay high until reset or clear_ovf; if clear_ovf and a new drop occur in the same cycle, overflow SHALL remain high.
REQ-024 The FSM SHALL have three states: IDLE, STREAM and DRAIN.
REQ-025 In IDLE, the FSM SHALL discard FIFO contents (pop without issue) while enable is low.
REQ-026 The FSM SHALL go from IDLE to STREAM when enable is high and the FIFO is not empty; idx SHALL be set to 0.
REQ-027 In STREAM, a pop SHALL occur in any cycle where the FIFO is not empty and sink_ready is high.
REQ-028 A pop in cycle N SHALL produce, in cycle N+1 only, sink_valid=1 with sink_real equal to the popped sample.
REQ-029 On that issued sample, sink_sop SHALL equal (idx==0) and sink_eop SHALL equal (idx==FRAME_LEN-1).
REQ-030 idx SHALL increment by one per pop and wrap to 0 after FRAME_LEN-1.
REQ-031 The pop with idx==FRAME_LEN-1 SHALL increment frames_in (mod 2^16).
REQ-032 After that pop, the FSM SHALL stay in STREAM if enable is high, otherwise go to DRAIN.
REQ-033 If enable falls mid-frame, the current frame SHALL be completed; the FSM SHALL remain in STREAM until the idx==FRAME_LEN-1 pop, then go to DRAIN.
REQ-034 DRAIN SHALL last exactly one cycle, with sink_valid/sop/eop low, then go to IDLE.
REQ-035 sink_valid, sink_sop and sink_eop SHALL be registered and SHALL be high for at most one cycle per sample.
REQ-036 sink_sop and sink_eop SHALL never be high without sink_valid.
REQ-037 When sink_ready is low, no pop SHALL occur; samples accumulate in the FIFO.
REQ-038 frames_out SHALL increment by one on each cycle where source_eop is high and wrap mod 2^16.
REQ-039 Latency, FIFO empty with sink_ready high: sample_valid in cycle N -> FIFO write in N -> pop in N+1 -> sink_valid in N+2.

Reset
REQ-040 On reset, all outputs SHALL be driven low or zero by the next clock edge, the FSM SHALL be in IDLE, the FIFO SHALL be empty, and idx, frames_in and frames_out SHALL be 0.
REQ-041 Reset SHALL take priority over every other input, including mid-frame; a partial frame is abandoned with no sink_eop issued.

Verification
REQ-042 enable=1, sink_ready=1, FRAME_LEN=64, one sample every 8 cycles -> 64 sink_valid pulses, each 2 cycles after its sample_valid, sop on the 1st, eop on the 64th, frames_in=1.
REQ-043 sink_ready held low for 40 cycles with a sample every 8 cycles and FIFO_DEPTH=4 -> 5th sample dropped, overflow=1, no sink_valid while ready is low; clear_ovf -> overflow=0.
REQ-044 enable dropped at idx=10 -> remaining 54 samples still issued with eop on the last, then DRAIN then IDLE; later samples are discarded with busy=0.
REQ-045 reset asserted at idx=30 -> next cycle sink_valid=0, busy=0, idx=0, FIFO empty; the following frame starts with sink_sop on its first sample.
REQ-046 FIFO full, push and pop in the same cycle -> push accepted, overflow stays 0.
REQ-047 65537 source_eop pulses -> frames_out=1 (wrap).

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Buffers audio samples in a small skid FIFO and streams them to an FFT
//   core in frames of FRAME_LEN samples. It marks the first and last sample
//   of each frame, flags dropped samples, and counts frames sent to and
//   received from the core.
//
// Ports
//   MCLK          : single clock
//   reset         : synchronous, active-high
//   enable        : level, permits new frames to start
//   sample_valid  : one-cycle strobe per audio sample
//   sample_data   : signed sample, qualified by sample_valid
//   sink_ready    : FFT core can accept input
//   source_eop    : FFT core end of output frame
//   clear_ovf     : pulse, clears the sticky overflow flag
//   sink_valid/sink_sop/sink_eop/sink_real/sink_imag : FFT input stream
//   busy          : a frame is in progress
//   overflow      : sticky, a sample was dropped
//   frames_in     : frames fully sent to the FFT core (mod 2^16)
//   frames_out    : source_eop pulses seen (mod 2^16)
module fft_frame_sequencer #(
  parameter int FRAME_LEN  = 1024,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     MCLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  input  logic                     sink_ready,
  input  logic                     source_eop,
  input  logic                     clear_ovf,
  output logic                     sink_valid,
  output logic                     sink_sop,
  output logic                     sink_eop,
  output logic signed [DATA_W-1:0] sink_real,
  output logic signed [DATA_W-1:0] sink_imag,
  output logic                     busy,
  output logic                     overflow,
  output logic [15:0]              frames_in,
  output logic [15:0]              frames_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic signed [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic                      overflow_q, overflow_d;
  logic [15:0]               frames_in_q, frames_in_d;
  logic [15:0]               frames_out_q, frames_out_d;
  logic                      sink_valid_q, sink_valid_d;
  logic                      sink_sop_q, sink_sop_d;
  logic                      sink_eop_q, sink_eop_d;
  logic signed [DATA_W-1:0]  sink_real_q, sink_real_d;

  logic                      fifo_empty, fifo_full;
  logic                      pop, issue, push, drop;
  logic [IW-1:0]             cur_idx;
  logic signed [DATA_W-1:0]  rd_data;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frames_in_d = frames_in_q;
    pop         = 1'b0;
    issue       = 1'b0;
    cur_idx     = idx_q;
    case (state_q)
      S_IDLE: begin
        cur_idx = '0;
        if (enable && !fifo_empty) begin
          // Start a frame; the first sample is issued in the same cycle so
          // the sample-to-output latency matches the streaming case.
          state_d = S_STREAM;
          idx_d   = '0;
          if (sink_ready) begin
            pop   = 1'b1;
            issue = 1'b1;
            idx_d = IW'(1);
          end
        end else if (!enable && !fifo_empty) begin
          pop = 1'b1;  // discard stale samples while disabled
        end
      end
      S_STREAM: begin
        if (!fifo_empty && sink_ready) begin
          pop   = 1'b1;
          issue = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(FRAME_LEN - 1)) begin
            frames_in_d = frames_in_q + 16'd1;
            if (!enable) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push         = sample_valid && (!fifo_full || pop);
    drop         = sample_valid && fifo_full && !pop;
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    // A new drop wins over a simultaneous clear.
    overflow_d   = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
    frames_out_d = frames_out_q + 16'(source_eop);
    sink_valid_d = issue;
    sink_sop_d   = issue && (cur_idx == '0);
    sink_eop_d   = issue && (cur_idx == IW'(FRAME_LEN - 1));
    sink_real_d  = issue ? rd_data : sink_real_q;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
      sink_valid_q <= 1'b0;
      sink_sop_q   <= 1'b0;
      sink_eop_q   <= 1'b0;
      sink_real_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      sink_valid_q <= sink_valid_d;
      sink_sop_q   <= sink_sop_d;
      sink_eop_q   <= sink_eop_d;
      sink_real_q  <= sink_real_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge MCLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sample_data;
  end

  assign sink_valid = sink_valid_q;
  assign sink_sop   = sink_sop_q;
  assign sink_eop   = sink_eop_q;
  assign sink_real  = sink_real_q;
  assign sink_imag  = '0;
  assign busy       = (state_q == S_STREAM);
  assign overflow   = overflow_q;
  assign frames_in  = frames_in_q;
  assign frames_out = frames_out_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
  localparam int DW = 24;
  localparam int FL = 64;
  localparam int FD = 4;

  logic          MCLK = 1'b0;
  logic          reset, enable, sample_valid, sink_ready, source_eop, clear_ovf;
  logic [DW-1:0] sample_data;
  logic          sink_valid, sink_sop, sink_eop, busy, overflow;
  logic [DW-1:0] sink_real, sink_imag;
  logic [15:0]   frames_in, frames_out;

  int checks = 0;
  int failures = 0;

  always #10 MCLK = ~MCLK;

  fft_frame_sequencer #(.FRAME_LEN(FL), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .MCLK(MCLK), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sink_ready(sink_ready), .source_eop(source_eop), .clear_ovf(clear_ovf),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .busy(busy),
    .overflow(overflow), .frames_in(frames_in), .frames_out(frames_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  function automatic logic [DW-1:0] sval(input int k);
    return DW'(k * 4099 - 200000);
  endfunction

  // Push one sample, expect it on the sink two edges later for one cycle.
  task automatic send_issue(input logic [DW-1:0] d, input logic sop, input logic eop,
                            input int pad);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("issue_valid", {31'b0, sink_valid}, 32'd1);
    chk("issue_real", {8'b0, sink_real}, {8'b0, d});
    chk("issue_sop", {31'b0, sink_sop}, {31'b0, sop});
    chk("issue_eop", {31'b0, sink_eop}, {31'b0, eop});
    tick();
    chk("issue_one_cycle", {31'b0, sink_valid}, 32'd0);
    repeat (pad) tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    sink_ready = 1'b0; source_eop = 1'b0; clear_ovf = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, sink_valid}, 32'd0);
    chk("rst_sop", {31'b0, sink_sop}, 32'd0);
    chk("rst_eop", {31'b0, sink_eop}, 32'd0);
    chk("rst_real", {8'b0, sink_real}, 32'd0);
    chk("rst_imag", {8'b0, sink_imag}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_frames_in", {16'b0, frames_in}, 32'd0);
    chk("rst_frames_out", {16'b0, frames_out}, 32'd0);
    reset = 1'b0;

    // Full frame, one sample every 8 cycles.
    enable = 1'b1;
    sink_ready = 1'b1;
    for (int k = 0; k < FL; k++) send_issue(sval(k), k == 0, k == FL - 1, 5);
    chk("frame1_frames_in", {16'b0, frames_in}, 32'd1);
    chk("frame1_busy_stays", {31'b0, busy}, 32'd1);

    // Sink stalled: four samples fill the FIFO, the fifth is dropped.
    sink_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1;
      sample_data  = sval(100 + k);
      tick();
      sample_valid = 1'b0;
      if (k == 3) chk("ovf_before_drop", {31'b0, overflow}, 32'd0);
      if (k == 4) chk("ovf_after_drop", {31'b0, overflow}, 32'd1);
      for (int c = 0; c < 7; c++) begin
        chk("stall_no_valid", {31'b0, sink_valid}, 32'd0);
        tick();
      end
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);
    // Clear and a new drop together: the drop wins.
    sample_valid = 1'b1;
    sample_data  = sval(150);
    clear_ovf    = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear_ovf    = 1'b0;
    chk("ovf_clear_vs_drop", {31'b0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared2", {31'b0, overflow}, 32'd0);

    // Full FIFO, push with simultaneous pop is accepted.
    sample_valid = 1'b1;
    sample_data  = sval(200);
    sink_ready   = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("full_push_pop_ovf", {31'b0, overflow}, 32'd0);
    chk("drain0_valid", {31'b0, sink_valid}, 32'd1);
    chk("drain0_real", {8'b0, sink_real}, {8'b0, sval(100)});
    chk("drain0_sop", {31'b0, sink_sop}, 32'd1);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("drain_valid", {31'b0, sink_valid}, 32'd1);
      chk("drain_real", {8'b0, sink_real}, {8'b0, sval(100 + j)});
      chk("drain_sop", {31'b0, sink_sop}, 32'd0);
    end
    tick();
    chk("drain4_valid", {31'b0, sink_valid}, 32'd1);
    chk("drain4_real", {8'b0, sink_real}, {8'b0, sval(200)});
    tick();
    chk("drain_done", {31'b0, sink_valid}, 32'd0);

    // Enable falls at idx 10; the frame still completes.
    for (int k = 5; k < FL; k++) begin
      if (k == 10) enable = 1'b0;
      send_issue(sval(300 + k), 1'b0, k == FL - 1, 0);
      if (k == 40) chk("busy_after_enable_low", {31'b0, busy}, 32'd1);
    end
    chk("frame2_frames_in", {16'b0, frames_in}, 32'd2);
    chk("idle_after_drain_busy", {31'b0, busy}, 32'd0);
    sample_valid = 1'b1;
    sample_data  = sval(400);
    tick();
    sample_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("discard_no_valid", {31'b0, sink_valid}, 32'd0);
      chk("discard_busy", {31'b0, busy}, 32'd0);
    end
    enable = 1'b1;
    send_issue(sval(500), 1'b1, 1'b0, 0);

    // Reset mid-frame at idx 30.
    for (int k = 1; k < 30; k++) send_issue(sval(600 + k), 1'b0, 1'b0, 0);
    source_eop = 1'b1;
    repeat (3) tick();
    source_eop = 1'b0;
    chk("frames_out_3", {16'b0, frames_out}, 32'd3);
    sample_valid = 1'b1;
    sample_data  = sval(630);
    tick();
    sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_valid", {31'b0, sink_valid}, 32'd0);
    chk("midrst_eop", {31'b0, sink_eop}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_frames_in", {16'b0, frames_in}, 32'd0);
    chk("midrst_frames_out", {16'b0, frames_out}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_fifo_empty", {31'b0, sink_valid}, 32'd0);
    end
    send_issue(sval(700), 1'b1, 1'b0, 0);

    // frames_out wraps after 65536 pulses.
    source_eop = 1'b1;
    repeat (65536) tick();
    source_eop = 1'b0;
    chk("frames_out_wrap0", {16'b0, frames_out}, 32'd0);
    source_eop = 1'b1;
    tick();
    source_eop = 1'b0;
    chk("frames_out_wrap1", {16'b0, frames_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
